// File: rtl/eth_ram_pkg.sv
// rtl/eth_ram_pkg.sv - shared types and constants for the Ethernet-to-HDMI frame RAM
package eth_ram_pkg;

    // RAM geometry shared by the Ethernet write side and the HDMI read side
    localparam int DEF_ADDR_WIDTH  = 13;
    localparam int DEF_FRAME_WORDS = 8192;

    // Per-packet start-address header length in bytes
    localparam int HDR_BYTES = 2;

    // Filler for the low byte of an odd trailing payload byte
    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        HDR_LO,
        DATA_HI,
        DATA_LO
    } wr_state_t;

endpackage

// File: rtl/eth_ram_wr_ctrl.sv
// rtl/eth_ram_wr_ctrl.sv - UDP payload to frame RAM write port (optional stats: ETH_RAM_WR_STAT_EN)
module eth_ram_wr_ctrl
    import eth_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  rx_sop,
    input  logic                  rx_eop,
    input  logic                  rx_vld,
    input  logic [7:0]            rx_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  frame_done,
`ifdef ETH_RAM_WR_STAT_EN
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           err_cnt,
    output logic [15:0]           frame_cnt,
`endif
    output logic                  hdr_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    wr_state_t             state;
    // Holds the header high byte in HDR_LO and the payload high byte in DATA_LO
    logic [7:0]            byte_latch;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  start_bad;
    logic                  do_write;
    logic                  pkt_end;
    logic [15:0]           wr_word;

    // Reserved header bits above ADDR_WIDTH fall off in the truncation
    assign start_addr = ADDR_WIDTH'({byte_latch, rx_data});
    assign start_bad  = 32'(start_addr) >= FRAME_WORDS;
    assign addr_inc   = (next_addr == LAST_ADDR) ? '0 : next_addr + ADDR_WIDTH'(1);

    // Decide whether the current byte completes a RAM word, and which word
    always_comb begin
        do_write = 1'b0;
        pkt_end  = 1'b0;
        wr_word  = {byte_latch, rx_data};
        if (rx_vld && !rx_sop) begin
            if (state == DATA_HI && rx_eop) begin
                do_write = 1'b1;
                pkt_end  = 1'b1;
                wr_word  = {rx_data, PAD_BYTE};
            end else if (state == DATA_LO) begin
                do_write = 1'b1;
                pkt_end  = rx_eop;
            end
        end
    end

    // Packet parser: header strip, byte pairing, error pulses
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state      <= IDLE;
            byte_latch <= 8'h00;
            hdr_err    <= 1'b0;
        end else begin
            hdr_err <= 1'b0;
            if (rx_vld) begin
                if (rx_sop && rx_eop) begin
                    hdr_err <= 1'b1;
                    state   <= IDLE;
                end else if (rx_sop) begin
                    // A sop in any state restarts parsing; a pending high byte is dropped
                    byte_latch <= rx_data;
                    state      <= HDR_LO;
                end else begin
                    case (state)
                        IDLE: state <= IDLE;
                        HDR_LO: begin
                            if (rx_eop || start_bad) begin
                                hdr_err <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state <= DATA_HI;
                            end
                        end
                        DATA_HI: begin
                            byte_latch <= rx_data;
                            state      <= rx_eop ? IDLE : DATA_LO;
                        end
                        DATA_LO: state <= rx_eop ? IDLE : DATA_HI;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // RAM write port and wrapping word address counter
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            next_addr  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (rx_vld && !rx_sop && state == HDR_LO && !rx_eop && !start_bad) begin
                next_addr <= start_addr;
            end else if (do_write) begin
                wr_en      <= 1'b1;
                wr_addr    <= next_addr;
                wr_data    <= wr_word;
                frame_done <= (next_addr == LAST_ADDR);
                next_addr  <= addr_inc;
            end
        end
    end

`ifdef ETH_RAM_WR_STAT_EN
    // Free-running wrap-around statistics
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            pkt_cnt   <= 16'h0000;
            err_cnt   <= 16'h0000;
            frame_cnt <= 16'h0000;
        end else begin
            if (pkt_end) begin
                pkt_cnt <= pkt_cnt + 16'h0001;
            end
            if (hdr_err) begin
                err_cnt <= err_cnt + 16'h0001;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_ram_wr_ctrl.sv
// tb/tb_eth_ram_wr_ctrl.sv - directed vector bench for eth_ram_wr_ctrl
module tb_eth_ram_wr_ctrl;

    typedef struct {
        logic        sop;
        logic        eop;
        logic        vld;
        logic [7:0]  d;
        logic        en;
        logic [12:0] a;
        logic [15:0] w;
        logic        fd;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        hdr_err;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    // Reduced frame so that a bad start address is reachable; last address 0x1DFF
    eth_ram_wr_ctrl #(
        .ADDR_WIDTH (13),
        .FRAME_WORDS(7680)
    ) dut (
        .wr_clk    (clk),
        .wr_rst_n  (rst_n),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .hdr_err   (hdr_err)
    );

    task automatic add(input logic sop, input logic eop, input logic vld, input logic [7:0] d,
                       input logic en, input logic [12:0] a, input logic [15:0] w,
                       input logic fd, input logic err);
        vec_t v;
        v.sop = sop; v.eop = eop; v.vld = vld; v.d = d;
        v.en = en; v.a = a; v.w = w; v.fd = fd; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic en, input logic [12:0] a,
                       input logic [15:0] w, input logic fd, input logic err);
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, hdr_err} !== {en, a, w, fd, err}) begin
            errors++;
            $display("FAIL %s[%0d]: got en=%b addr=%h data=%h fd=%b err=%b, want en=%b addr=%h data=%h fd=%b err=%b",
                     nm, idx, wr_en, wr_addr, wr_data, frame_done, hdr_err, en, a, w, fd, err);
        end
    endtask

    task automatic apply(input string nm, input int idx, input vec_t v);
        @(negedge clk);
        rx_sop  = v.sop;
        rx_eop  = v.eop;
        rx_vld  = v.vld;
        rx_data = v.d;
        @(posedge clk);
        #1;
        chk(nm, idx, v.en, v.a, v.w, v.fd, v.err);
    endtask

    task automatic hand(input string nm, input logic sop, input logic eop, input logic [7:0] d,
                        input logic en, input logic [12:0] a, input logic [15:0] w);
        vec_t v;
        v.sop = sop; v.eop = eop; v.vld = 1'b1; v.d = d;
        v.en = en; v.a = a; v.w = w; v.fd = 1'b0; v.err = 1'b0;
        apply(nm, 0, v);
    endtask

    initial begin
        // normal packet 00 10 AB CD 12 34
        add(1,0,1,8'h00, 0,13'h0000,16'h0000,0,0);
        add(0,0,1,8'h10, 0,13'h0000,16'h0000,0,0);
        add(0,0,1,8'hAB, 0,13'h0000,16'h0000,0,0);
        add(0,0,1,8'hCD, 1,13'h0010,16'hABCD,0,0);
        add(0,0,1,8'h12, 0,13'h0010,16'hABCD,0,0);
        add(0,1,1,8'h34, 1,13'h0011,16'h1234,0,0);
        // odd length 00 05 11 22 33, then stray idle bytes
        add(1,0,1,8'h00, 0,13'h0011,16'h1234,0,0);
        add(0,0,1,8'h05, 0,13'h0011,16'h1234,0,0);
        add(0,0,1,8'h11, 0,13'h0011,16'h1234,0,0);
        add(0,0,1,8'h22, 1,13'h0005,16'h1122,0,0);
        add(0,1,1,8'h33, 1,13'h0006,16'h3300,0,0);
        add(0,0,1,8'h77, 0,13'h0006,16'h3300,0,0);
        add(0,1,1,8'h88, 0,13'h0006,16'h3300,0,0);
        // wrap at last frame word 0x1DFF
        add(1,0,1,8'h1D, 0,13'h0006,16'h3300,0,0);
        add(0,0,1,8'hFF, 0,13'h0006,16'h3300,0,0);
        add(0,0,1,8'hAA, 0,13'h0006,16'h3300,0,0);
        add(0,0,1,8'hBB, 1,13'h1DFF,16'hAABB,1,0);
        add(0,0,1,8'hCC, 0,13'h1DFF,16'hAABB,0,0);
        add(0,1,1,8'hDD, 1,13'h0000,16'hCCDD,0,0);
        // bad header 1E 00 (== FRAME_WORDS), payload discarded, then header 00 00
        add(1,0,1,8'h1E, 0,13'h0000,16'hCCDD,0,0);
        add(0,0,1,8'h00, 0,13'h0000,16'hCCDD,0,1);
        add(0,0,1,8'h55, 0,13'h0000,16'hCCDD,0,0);
        add(0,0,1,8'h66, 0,13'h0000,16'hCCDD,0,0);
        add(0,1,1,8'h77, 0,13'h0000,16'hCCDD,0,0);
        add(1,0,1,8'h00, 0,13'h0000,16'hCCDD,0,0);
        add(0,0,1,8'h00, 0,13'h0000,16'hCCDD,0,0);
        add(0,0,1,8'h12, 0,13'h0000,16'hCCDD,0,0);
        add(0,1,1,8'h34, 1,13'h0000,16'h1234,0,0);
        // truncated packet: 03 dropped by new sop, no error
        add(1,0,1,8'h00, 0,13'h0000,16'h1234,0,0);
        add(0,0,1,8'h20, 0,13'h0000,16'h1234,0,0);
        add(0,0,1,8'h01, 0,13'h0000,16'h1234,0,0);
        add(0,0,1,8'h02, 1,13'h0020,16'h0102,0,0);
        add(0,0,1,8'h03, 0,13'h0020,16'h0102,0,0);
        add(1,0,1,8'h00, 0,13'h0020,16'h0102,0,0);
        add(0,0,1,8'h40, 0,13'h0020,16'h0102,0,0);
        add(0,0,1,8'h05, 0,13'h0020,16'h0102,0,0);
        add(0,1,1,8'h06, 1,13'h0040,16'h0506,0,0);
        // reserved header bits E0 10 -> start 0x0010, with rx_vld gaps and junk strobes
        add(1,0,1,8'hE0, 0,13'h0040,16'h0506,0,0);
        add(0,0,0,8'h55, 0,13'h0040,16'h0506,0,0);
        add(1,1,0,8'hFF, 0,13'h0040,16'h0506,0,0);
        add(0,0,1,8'h10, 0,13'h0040,16'h0506,0,0);
        add(0,0,1,8'h9A, 0,13'h0040,16'h0506,0,0);
        add(0,0,0,8'h00, 0,13'h0040,16'h0506,0,0);
        add(0,0,1,8'hBC, 1,13'h0010,16'h9ABC,0,0);
        add(0,0,0,8'h00, 0,13'h0010,16'h9ABC,0,0);
        add(0,0,1,8'hDE, 0,13'h0010,16'h9ABC,0,0);
        add(0,0,0,8'h00, 0,13'h0010,16'h9ABC,0,0);
        add(0,1,1,8'hF0, 1,13'h0011,16'hDEF0,0,0);
        // sop+eop together, eop on header low byte, sop+eop mid-payload
        add(1,1,1,8'h00, 0,13'h0011,16'hDEF0,0,1);
        add(1,0,1,8'h00, 0,13'h0011,16'hDEF0,0,0);
        add(0,1,1,8'h08, 0,13'h0011,16'hDEF0,0,1);
        add(1,0,1,8'h00, 0,13'h0011,16'hDEF0,0,0);
        add(0,0,1,8'h30, 0,13'h0011,16'hDEF0,0,0);
        add(0,0,1,8'hAA, 0,13'h0011,16'hDEF0,0,0);
        add(1,1,1,8'h00, 0,13'h0011,16'hDEF0,0,1);
        add(0,1,1,8'hBB, 0,13'h0011,16'hDEF0,0,0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 13'h0000, 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply("vec", i, tbl[i]);
        end

        // reset while in DATA_LO with a pending high byte
        hand("rst_seq", 1, 0, 8'h00, 0, 13'h0011, 16'hDEF0);
        hand("rst_seq", 0, 0, 8'h50, 0, 13'h0011, 16'hDEF0);
        hand("rst_seq", 0, 0, 8'hAB, 0, 13'h0011, 16'hDEF0);
        hand("rst_seq", 0, 0, 8'hCD, 1, 13'h0050, 16'hABCD);
        hand("rst_seq", 0, 0, 8'hEF, 0, 13'h0050, 16'hABCD);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_data_lo", 0, 0, 13'h0000, 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hand("post_rst", 1, 0, 8'h00, 0, 13'h0000, 16'h0000);
        hand("post_rst", 0, 0, 8'h60, 0, 13'h0000, 16'h0000);
        hand("post_rst", 0, 0, 8'h12, 0, 13'h0000, 16'h0000);
        hand("post_rst", 0, 1, 8'h34, 1, 13'h0060, 16'h1234);
        // reset during an in-flight write pulse
        #2 rst_n = 1'b0;
        #1 chk("async_rst_wr_en", 0, 0, 13'h0000, 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_vld = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
